// File: rtl/iob_picorv32_bus_split.sv
// Routes PicoRV32 native accesses to the instruction IOb bus or one of N data IOb buses.
// Generates write completion locally and terminates bad selects and unanswered requests.
//
// state   | meaning
// IDLE    | waiting for cpu_valid_i, latches the request
// REQ     | avalid on the selected channel until ready
// RESP    | read accepted, waiting for rvalid
// DONE    | one-cycle cpu_ready_o pulse
module iob_picorv32_bus_split #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_W    = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk_i,
  input  logic                         cke_i,
  input  logic                         rst_i,
  input  logic                         cpu_valid_i,
  input  logic                         cpu_instr_i,
  input  logic [ADDR_W-1:0]            cpu_addr_i,
  input  logic [DATA_W-1:0]            cpu_wdata_i,
  input  logic [DATA_W/8-1:0]          cpu_wstrb_i,
  output logic [DATA_W-1:0]            cpu_rdata_o,
  output logic                         cpu_ready_o,
  output logic                         ibus_avalid_o,
  output logic [ADDR_W-1:0]            ibus_address_o,
  output logic [DATA_W-1:0]            ibus_wdata_o,
  output logic [DATA_W/8-1:0]          ibus_wstrb_o,
  input  logic [DATA_W-1:0]            ibus_rdata_i,
  input  logic                         ibus_rvalid_i,
  input  logic                         ibus_ready_i,
  output logic [N_SLAVES-1:0]          dbus_avalid_o,
  output logic [N_SLAVES*ADDR_W-1:0]   dbus_address_o,
  output logic [N_SLAVES*DATA_W-1:0]   dbus_wdata_o,
  output logic [N_SLAVES*DATA_W/8-1:0] dbus_wstrb_o,
  input  logic [N_SLAVES*DATA_W-1:0]   dbus_rdata_i,
  input  logic [N_SLAVES-1:0]          dbus_rvalid_i,
  input  logic [N_SLAVES-1:0]          dbus_ready_i,
  input  logic                         err_clr_i,
  output logic                         err_o,
  output logic                         err_cause_o,
  output logic [ADDR_W-1:0]            err_addr_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              instr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              err_cause_q;
  logic [ADDR_W-1:0] err_addr_q;

  logic [SEL_W-1:0]  cpu_sel;
  logic              decode_bad;
  logic              busy;
  logic              tmo;
  logic              sel_ready;
  logic              sel_rvalid;
  logic [DATA_W-1:0] sel_rdata;
  logic              err_event;
  logic              err_event_cause;
  logic [ADDR_W-1:0] err_event_addr;

  assign cpu_sel    = cpu_addr_i[ADDR_W-1 -: SEL_W];
  assign decode_bad = !cpu_instr_i && (int'(cpu_sel) >= N_SLAVES);
  assign busy       = (state_q == ST_REQ) || (state_q == ST_RESP);
  assign tmo        = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  assign cpu_ready_o = (state_q == ST_DONE);
  assign cpu_rdata_o = (state_q == ST_DONE) ? rdata_q : '0;
  assign err_o       = err_q;
  assign err_cause_o = err_cause_q;
  assign err_addr_o  = err_addr_q;

  // Only the latched channel sees a request or is listened to; everything else reads as zero.
  always_comb begin
    sel_ready      = 1'b0;
    sel_rvalid     = 1'b0;
    sel_rdata      = '0;
    ibus_avalid_o  = 1'b0;
    ibus_address_o = '0;
    ibus_wdata_o   = '0;
    ibus_wstrb_o   = '0;
    dbus_avalid_o  = '0;
    dbus_address_o = '0;
    dbus_wdata_o   = '0;
    dbus_wstrb_o   = '0;
    if (instr_q) begin
      sel_ready  = ibus_ready_i;
      sel_rvalid = ibus_rvalid_i;
      sel_rdata  = ibus_rdata_i;
      if (state_q == ST_REQ) begin
        ibus_avalid_o  = 1'b1;
        ibus_address_o = addr_q;
        ibus_wdata_o   = wdata_q;
        ibus_wstrb_o   = wstrb_q;
      end
    end else begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (sel_q == SEL_W'(i)) begin
          sel_ready  = dbus_ready_i[i];
          sel_rvalid = dbus_rvalid_i[i];
          sel_rdata  = dbus_rdata_i[i*DATA_W +: DATA_W];
          if (state_q == ST_REQ) begin
            dbus_avalid_o[i]                   = 1'b1;
            dbus_address_o[i*ADDR_W +: ADDR_W] = addr_q;
            dbus_wdata_o[i*DATA_W +: DATA_W]   = wdata_q;
            dbus_wstrb_o[i*STRB_W +: STRB_W]   = wstrb_q;
          end
        end
      end
    end
  end

  always_comb begin
    err_event       = 1'b0;
    err_event_cause = 1'b0;
    err_event_addr  = cpu_addr_i;
    if (state_q == ST_IDLE) begin
      err_event = cpu_valid_i && decode_bad;
    end else if (busy && tmo) begin
      err_event       = 1'b1;
      err_event_cause = 1'b1;
      err_event_addr  = addr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      instr_q     <= 1'b0;
      sel_q       <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      err_cause_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (cke_i) begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_valid_i) begin
            addr_q  <= cpu_addr_i;
            wdata_q <= cpu_wdata_i;
            wstrb_q <= cpu_wstrb_i;
            instr_q <= cpu_instr_i;
            sel_q   <= cpu_sel;
            rdata_q <= '0;
            cnt_q   <= '0;
            state_q <= decode_bad ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (tmo) begin
            state_q <= ST_DONE;
          end else begin
            if (TIMEOUT != 0) cnt_q <= cnt_q + CNT_W'(1);
            if (sel_ready) state_q <= (wstrb_q != '0) ? ST_DONE : ST_RESP;
          end
        end
        ST_RESP: begin
          if (tmo) begin
            state_q <= ST_DONE;
          end else begin
            if (TIMEOUT != 0) cnt_q <= cnt_q + CNT_W'(1);
            if (sel_rvalid) begin
              rdata_q <= sel_rdata;
              state_q <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A clear and a fresh error in the same cycle leave the fresh error recorded.
      if (err_event && (!err_q || err_clr_i)) begin
        err_q       <= 1'b1;
        err_cause_q <= err_event_cause;
        err_addr_q  <= err_event_addr;
      end else if (err_clr_i) begin
        err_q       <= 1'b0;
        err_cause_q <= 1'b0;
        err_addr_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iob_picorv32_bus_split.sv
// Self-checking bench for iob_picorv32_bus_split: directed scenarios plus randomized
// accesses checked against a latency/routing/error model computed from the access rules.
module tb_iob_picorv32_bus_split;

  localparam int NS  = 3;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        cke, rst;
  logic        cpu_valid, cpu_instr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        ibus_avalid;
  logic [31:0] ibus_address, ibus_wdata;
  logic [3:0]  ibus_wstrb;
  logic [31:0] ibus_rdata;
  logic        ibus_rvalid, ibus_ready;
  logic [NS-1:0]    dbus_avalid;
  logic [NS*32-1:0] dbus_address, dbus_wdata;
  logic [NS*4-1:0]  dbus_wstrb;
  logic [NS*32-1:0] dbus_rdata;
  logic [NS-1:0]    dbus_rvalid, dbus_ready;
  logic        err_clr, err, err_cause;
  logic [31:0] err_addr;

  int n_cmp = 0;
  int n_bad = 0;

  iob_picorv32_bus_split #(
    .ADDR_W(32), .DATA_W(32), .N_SLAVES(NS), .SEL_W(2), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
    .cpu_valid_i(cpu_valid), .cpu_instr_i(cpu_instr), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_wstrb_i(cpu_wstrb),
    .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
    .ibus_avalid_o(ibus_avalid), .ibus_address_o(ibus_address),
    .ibus_wdata_o(ibus_wdata), .ibus_wstrb_o(ibus_wstrb),
    .ibus_rdata_i(ibus_rdata), .ibus_rvalid_i(ibus_rvalid), .ibus_ready_i(ibus_ready),
    .dbus_avalid_o(dbus_avalid), .dbus_address_o(dbus_address),
    .dbus_wdata_o(dbus_wdata), .dbus_wstrb_o(dbus_wstrb),
    .dbus_rdata_i(dbus_rdata), .dbus_rvalid_i(dbus_rvalid), .dbus_ready_i(dbus_ready),
    .err_clr_i(err_clr), .err_o(err), .err_cause_o(err_cause), .err_addr_o(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one access from an IDLE cycle and acts as the bus slave. Mask bit 3 is ibus,
  // bits 0..2 are dbus channels. Returns the cycle of cpu_ready (-1 if never seen).
  task automatic run_access(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int rdy_dly, input int rv_dly,
                            input logic [31:0] rsp, input int cke_at, input logic stray,
                            input logic clr_first, output int lat, output logic [31:0] rdata,
                            output logic [3:0] mask, output int av_cycles, output logic fields_ok);
    int ch, w, rvw, acc_k;
    logic accepted, rv_done, av_now;
    logic [3:0] sel_mask;
    ch = instr ? 3 : int'(addr[31:30]);
    sel_mask = 4'b0001 << ch;
    if (cpu_ready) @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    err_clr = clr_first;
    lat = -1; rdata = '0; mask = '0; av_cycles = 0; fields_ok = 1'b1;
    w = 0; rvw = 0; acc_k = -1; accepted = 1'b0; rv_done = (rv_dly < 0) || (wstrb != 0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      err_clr = 1'b0; cke = 1'b1;
      ibus_ready = 1'b0; ibus_rvalid = 1'b0; dbus_ready = '0; dbus_rvalid = '0;
      ibus_rdata = $urandom; dbus_rdata = {$urandom, $urandom, $urandom};
      av_now = 1'b0;
      if (ibus_avalid) begin
        mask[3] = 1'b1; av_cycles++; av_now = (ch == 3);
        if (ibus_address !== addr || ibus_wdata !== wdata || ibus_wstrb !== wstrb) fields_ok = 1'b0;
      end else if ({ibus_address, ibus_wdata, ibus_wstrb} !== '0) fields_ok = 1'b0;
      for (int c = 0; c < NS; c++) begin
        if (dbus_avalid[c]) begin
          mask[c] = 1'b1; av_cycles++; if (ch == c) av_now = 1'b1;
          if (dbus_address[c*32 +: 32] !== addr || dbus_wdata[c*32 +: 32] !== wdata ||
              dbus_wstrb[c*4 +: 4] !== wstrb) fields_ok = 1'b0;
        end else if ({dbus_address[c*32 +: 32], dbus_wdata[c*32 +: 32], dbus_wstrb[c*4 +: 4]} !== '0)
          fields_ok = 1'b0;
      end
      if (cpu_ready) begin
        lat = k; rdata = cpu_rdata; cpu_valid = 1'b0;
        break;
      end
      cke = !(cke_at >= 0 && (k == cke_at || k == cke_at + 1));
      if (stray) begin
        dbus_rvalid = ~sel_mask[NS-1:0];
        ibus_rvalid = ~sel_mask[3];
      end
      if (av_now && !accepted && cke) begin
        if (w == rdy_dly) begin
          if (ch == 3) ibus_ready = 1'b1; else dbus_ready[ch] = 1'b1;
          accepted = 1'b1; acc_k = k;
        end else w++;
      end else if (accepted && !rv_done && k > acc_k && cke) begin
        if (rvw == rv_dly) begin
          if (ch == 3) begin ibus_rvalid = 1'b1; ibus_rdata = rsp; end
          else begin dbus_rvalid[ch] = 1'b1; dbus_rdata[ch*32 +: 32] = rsp; end
          rv_done = 1'b1;
        end else rvw++;
      end
    end
    if (lat < 0) cpu_valid = 1'b0;
  endtask

  task automatic test_reset();
    cke = 1'b1; rst = 1'b1; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_wstrb = '0; err_clr = 1'b0;
    ibus_rdata = '0; ibus_rvalid = 1'b0; ibus_ready = 1'b0;
    dbus_rdata = '0; dbus_rvalid = '0; dbus_ready = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({cpu_ready, ibus_avalid, dbus_avalid} !== '0) begin
      n_bad++; $display("FAIL reset_valids: got %b expected 0", {cpu_ready, ibus_avalid, dbus_avalid});
    end
    n_cmp++;
    if ({cpu_rdata, ibus_address, dbus_address, ibus_wstrb, dbus_wstrb} !== '0) begin
      n_bad++; $display("FAIL reset_fields: got nonzero expected 0");
    end
    n_cmp++;
    if ({err, err_cause, err_addr} !== '0) begin
      n_bad++; $display("FAIL reset_err: got %b/%b/%h expected 0", err, err_cause, err_addr);
    end
  endtask

  task automatic test_instr_fetch();
    int lat, av; logic [31:0] rd; logic [3:0] m; logic ok;
    run_access(1'b1, 32'h1000_0000, 32'h1234_5678, 4'h0, 0, 0, 32'h0000_0013, -1, 1'b1, 1'b0,
               lat, rd, m, av, ok);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL fetch_latency: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 32'h13) begin n_bad++; $display("FAIL fetch_rdata: got %h expected 00000013", rd); end
    n_cmp++; if (m !== 4'b1000) begin n_bad++; $display("FAIL fetch_route: got %b expected 1000", m); end
    n_cmp++; if (!ok || av != 1) begin n_bad++; $display("FAIL fetch_fields: ok %b cycles %0d expected 1/1", ok, av); end
  endtask

  task automatic test_write_routing();
    int lat, av; logic [31:0] rd; logic [3:0] m; logic ok;
    run_access(1'b0, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 32'hDEAD_BEEF, -1, 1'b1, 1'b0,
               lat, rd, m, av, ok);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL write_latency: got %0d expected 2", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL write_rdata: got %h expected 0", rd); end
    n_cmp++; if (m !== 4'b0100) begin n_bad++; $display("FAIL write_route: got %b expected 0100", m); end
    n_cmp++; if (!ok || av != 1) begin n_bad++; $display("FAIL write_fields: ok %b cycles %0d expected 1/1", ok, av); end
  endtask

  task automatic test_decode_error();
    int lat, av; logic [31:0] rd; logic [3:0] m; logic ok;
    run_access(1'b0, 32'hC000_0000, 32'h0, 4'h0, 0, 0, 32'h5555_5555, -1, 1'b0, 1'b0,
               lat, rd, m, av, ok);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL decode_latency: got %0d expected 1", lat); end
    n_cmp++; if (m !== 4'b0000 || rd !== 32'h0) begin n_bad++; $display("FAIL decode_bus: mask %b rdata %h expected 0/0", m, rd); end
    n_cmp++;
    if ({err, err_cause, err_addr} !== {1'b1, 1'b0, 32'hC000_0000}) begin
      n_bad++; $display("FAIL decode_err: got %b/%b/%h expected 1/0/c0000000", err, err_cause, err_addr);
    end
  endtask

  task automatic test_timeout();
    int lat, av; logic [31:0] rd; logic [3:0] m; logic ok;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clear_before_tmo: got %b expected 0", err); end
    run_access(1'b0, 32'h4000_0020, 32'h0, 4'h0, 0, -1, 32'h0, -1, 1'b0, 1'b0, lat, rd, m, av, ok);
    n_cmp++; if (lat !== TMO + 2) begin n_bad++; $display("FAIL tmo_latency: got %0d expected %0d", lat, TMO + 2); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL tmo_rdata: got %h expected 0", rd); end
    n_cmp++;
    if ({err, err_cause, err_addr} !== {1'b1, 1'b1, 32'h4000_0020}) begin
      n_bad++; $display("FAIL tmo_err: got %b/%b/%h expected 1/1/40000020", err, err_cause, err_addr);
    end
    @(negedge clk); dbus_rvalid[1] = 1'b1; dbus_rdata[63:32] = 32'h7777_7777;
    @(negedge clk); dbus_rvalid = '0;
    n_cmp++;
    if (cpu_ready !== 1'b0 || dbus_avalid !== '0) begin
      n_bad++; $display("FAIL late_rvalid: ready %b avalid %b expected 0/0", cpu_ready, dbus_avalid);
    end
    run_access(1'b0, 32'hC000_0040, 32'h0, 4'h0, 0, 0, 32'h0, -1, 1'b0, 1'b0, lat, rd, m, av, ok);
    n_cmp++;
    if ({err, err_cause, err_addr} !== {1'b1, 1'b1, 32'h4000_0020}) begin
      n_bad++; $display("FAIL sticky_err: got %b/%b/%h expected 1/1/40000020", err, err_cause, err_addr);
    end
    run_access(1'b0, 32'hC000_0080, 32'h0, 4'h0, 0, 0, 32'h0, -1, 1'b0, 1'b1, lat, rd, m, av, ok);
    n_cmp++;
    if ({err, err_cause, err_addr} !== {1'b1, 1'b0, 32'hC000_0080}) begin
      n_bad++; $display("FAIL clr_vs_new_err: got %b/%b/%h expected 1/0/c0000080", err, err_cause, err_addr);
    end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    n_cmp++;
    if ({err, err_cause, err_addr} !== '0) begin
      n_bad++; $display("FAIL err_clear: got %b/%b/%h expected 0/0/0", err, err_cause, err_addr);
    end
  endtask

  task automatic test_stall_cke_b2b();
    int lat0, lat1, lat2, av; logic [31:0] rd; logic [3:0] m; logic ok;
    run_access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 32'h1111_2222, -1, 1'b0, 1'b0, lat0, rd, m, av, ok);
    n_cmp++; if (lat0 !== 3) begin n_bad++; $display("FAIL base_latency: got %0d expected 3", lat0); end
    // ready held off 3 cycles, cke low for the first two RESP cycles (cycle 5 and 6)
    run_access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 3, 0, 32'h3333_4444, 5, 1'b1, 1'b0, lat1, rd, m, av, ok);
    n_cmp++; if (lat1 !== 8) begin n_bad++; $display("FAIL stall_latency: got %0d expected 8", lat1); end
    n_cmp++; if (rd !== 32'h3333_4444) begin n_bad++; $display("FAIL stall_rdata: got %h expected 33334444", rd); end
    run_access(1'b0, 32'h4000_0200, 32'h0, 4'h0, 0, 0, 32'h5555_6666, -1, 1'b1, 1'b0, lat2, rd, m, av, ok);
    n_cmp++;
    if (lat2 !== 3 || rd !== 32'h5555_6666) begin
      n_bad++; $display("FAIL b2b_access: lat %0d rdata %h expected 3/55556666", lat2, rd);
    end
  endtask

  task automatic test_random();
    int lat, av, rdy, rv, sel, e_lat, e_av, busy;
    logic instr, is_wr, decode, tmo_hit, clr, strayv, ok;
    logic [3:0] wstrb, m, e_mask;
    logic [31:0] addr, rsp, rd, e_rd;
    logic m_err, m_cause;
    logic [31:0] m_addr;
    m_err = 1'b0; m_cause = 1'b0; m_addr = '0;
    for (int it = 0; it < 30; it++) begin
      instr  = ($urandom_range(0, 3) == 0);
      sel    = $urandom_range(0, 3);
      addr   = {2'(sel), 30'($urandom)};
      wstrb  = (!instr && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      is_wr  = (wstrb != 0);
      rdy    = $urandom_range(0, 3);
      rv     = (!is_wr && $urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
      rsp    = $urandom;
      clr    = ($urandom_range(0, 3) == 0);
      strayv = $urandom_range(0, 1);
      run_access(instr, addr, $urandom, wstrb, rdy, rv, rsp, -1, strayv, clr, lat, rd, m, av, ok);

      decode = !instr && (sel >= NS);
      busy   = (rdy + 1) + (is_wr ? 0 : ((rv < 0) ? 1000 : rv + 1));
      tmo_hit = !decode && (busy > TMO);
      e_lat  = decode ? 1 : (tmo_hit ? TMO + 2 : busy + 1);
      e_rd   = (decode || tmo_hit || is_wr) ? 32'h0 : rsp;
      e_mask = decode ? 4'b0000 : (instr ? 4'b1000 : 4'(1 << sel));
      e_av   = decode ? 0 : rdy + 1;
      if (clr) begin m_err = 1'b0; m_cause = 1'b0; m_addr = '0; end
      if ((decode || tmo_hit) && !m_err) begin m_err = 1'b1; m_cause = tmo_hit; m_addr = addr; end

      n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, lat, e_lat); end
      n_cmp++; if (rd !== e_rd) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h expected %h", it, rd, e_rd); end
      n_cmp++; if (m !== e_mask) begin n_bad++; $display("FAIL rnd%0d_route: got %b expected %b", it, m, e_mask); end
      n_cmp++; if (av !== e_av) begin n_bad++; $display("FAIL rnd%0d_avalid_cycles: got %0d expected %0d", it, av, e_av); end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_fields: got %b expected 1", it, ok); end
      n_cmp++;
      if ({err, err_cause, err_addr} !== {m_err, m_cause, m_addr}) begin
        n_bad++; $display("FAIL rnd%0d_err: got %b/%b/%h expected %b/%b/%h", it, err, err_cause, err_addr, m_err, m_cause, m_addr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, av; logic [31:0] rd; logic [3:0] m; logic ok;
    logic seen_ready;
    run_access(1'b0, 32'hC000_0004, 32'h0, 4'h0, 0, 0, 32'h0, -1, 1'b0, 1'b0, lat, rd, m, av, ok);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL pre_reset_err: got %b expected 1", err); end
    @(negedge clk);
    cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h4000_0044; cpu_wdata = 32'hABCD_0123; cpu_wstrb = 4'h0;
    @(negedge clk); dbus_ready[1] = 1'b1;
    @(negedge clk); dbus_ready = '0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_valid = 1'b0;
    n_cmp++;
    if ({cpu_ready, ibus_avalid, dbus_avalid, cpu_rdata} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: ready %b avalid %b rdata %h expected 0", cpu_ready, dbus_avalid, cpu_rdata);
    end
    n_cmp++;
    if ({dbus_address, dbus_wdata, dbus_wstrb, ibus_address, ibus_wdata, ibus_wstrb} !== '0) begin
      n_bad++; $display("FAIL mid_reset_fields: got nonzero expected 0");
    end
    n_cmp++;
    if ({err, err_cause, err_addr} !== '0) begin
      n_bad++; $display("FAIL mid_reset_err: got %b/%b/%h expected 0", err, err_cause, err_addr);
    end
    dbus_rvalid[1] = 1'b1; dbus_rdata[63:32] = 32'h9999_8888;
    seen_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      dbus_rvalid = '0;
      if (cpu_ready || dbus_avalid != '0) seen_ready = 1'b1;
    end
    n_cmp++;
    if (seen_ready !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_rvalid: activity %b expected 0", seen_ready);
    end
  endtask

  initial begin
    test_reset();
    test_instr_fetch();
    test_write_routing();
    test_decode_error();
    test_timeout();
    test_stall_cke_b2b();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
